// File: rtl/serial_adder_pkg.sv
// ---------------------------------------------------------------------------
// serial_adder_pkg: shared FSM state type and counter sizing for serial_digit_adder
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int nslice);
    return (nslice > 1) ? $clog2(nslice) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/digit_slice_adder.sv
// ---------------------------------------------------------------------------
// digit_slice_adder: DIGIT-bit combinational ripple of full-adder cells
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module digit_slice_adder #(
  parameter int DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             ci,
  output logic [DIGIT-1:0] s,
  output logic             co
);

  logic [DIGIT:0] c;

  assign c[0] = ci;

  for (genvar i = 0; i < DIGIT; i++) begin : g_fa
    assign s[i]   = x[i] ^ y[i] ^ c[i];
    assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
  end

  assign co = c[DIGIT];

endmodule

`default_nettype wire

// File: rtl/serial_digit_adder.sv
// ---------------------------------------------------------------------------
// serial_digit_adder: multi-cycle WIDTH-bit adder, DIGIT bits per clock, valid/ready.
// Optional subtract mode via macro SERIAL_DIGIT_ADDER_SUB_EN.  Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_digit_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int NSLICE = WIDTH / DIGIT;
  localparam int CW     = cnt_width(NSLICE);

  if ((DIGIT < 1) || (WIDTH < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_cfg
    $error("serial_digit_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t           state, state_next;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg, sum_reg;
  logic             carry, cout_reg, valid_reg;
  logic [DIGIT-1:0] slice_s;
  logic             slice_co;
  logic             accept, last, emit;

  assign accept = (state == IDLE) && in_valid;
  assign last   = (cnt == CW'(NSLICE - 1));
  assign emit   = valid_reg && out_ready;

  // Operands shift right each ADD cycle, so the slice always reads the low digit.
  digit_slice_adder #(.DIGIT(DIGIT)) u_slice (
    .x  (a_reg[DIGIT-1:0]),
    .y  (b_reg[DIGIT-1:0]),
    .ci (carry),
    .s  (slice_s),
    .co (slice_co)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = ADD;
      ADD:     if (last)   state_next = DONE;
      DONE:    if (emit)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      sum_reg   <= '0;
      carry     <= 1'b0;
      cout_reg  <= 1'b0;
      valid_reg <= 1'b0;
    end else begin
      if (accept) begin
        cnt   <= '0;
        a_reg <= a;
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
        b_reg <= sub ? ~b : b;
        carry <= sub ? 1'b1 : cin;
`else
        b_reg <= b;
        carry <= cin;
`endif
      end else if (state == ADD) begin
        a_reg <= a_reg >> DIGIT;
        b_reg <= b_reg >> DIGIT;
        carry <= slice_co;
        cnt   <= cnt + 1'b1;
        for (int k = 0; k < NSLICE; k++) begin
          if (cnt == CW'(k)) sum_reg[k*DIGIT +: DIGIT] <= slice_s;
        end
        if (last) cout_reg <= slice_co;
      end
      // Result is flagged one cycle after the last slice lands in DONE.
      if (emit)                valid_reg <= 1'b0;
      else if (state == DONE)  valid_reg <= 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = valid_reg;
  assign sum       = sum_reg;
  assign cout      = cout_reg;

endmodule

`default_nettype wire

// File: tb/tb_serial_digit_adder.sv
// ---------------------------------------------------------------------------
// tb_serial_digit_adder: four WIDTH=8 instances (DIGIT 1,2,4,8) driven in lockstep
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_digit_adder;

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n, in_valid, cin, out_ready, sub;
  logic [7:0] a, b;
  logic [3:0] in_ready_v, out_valid_v, busy_v, cout_v;
  logic [7:0] sum_v [4];

  int         vectors     = 0;
  int         miscompares = 0;
  logic [7:0] exp_sum;
  logic       exp_cout;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    serial_digit_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready_v[g]),
      .a         (a),
      .b         (b),
      .cin       (cin),
`ifdef SERIAL_DIGIT_ADDER_SUB_EN
      .sub       (sub),
`endif
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready),
      .sum       (sum_v[g]),
      .cout      (cout_v[g]),
      .busy      (busy_v[g])
    );
  end

  // Reference: plain integer arithmetic; subtraction yields no-borrow flag.
  function automatic logic [8:0] ref_op(input logic [7:0] x, input logic [7:0] y,
                                        input logic c, input logic s);
    int r;
    if (s) begin
      r = int'(x) - int'(y);
      return {(x >= y), r[7:0]};
    end
    r = int'(x) + int'(y) + int'(c);
    return r[8:0];
  endfunction

  task automatic check(input string tag, input int d, input logic [31:0] obs,
                       input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s [digit=%0d]: observed 0x%0h expected 0x%0h", tag, d, obs, expv);
    end
  endtask

  task automatic start_op(input logic [7:0] av, input logic [7:0] bv,
                          input logic cv, input logic sv);
    logic [8:0] r;
    @(negedge clk);
    a = av; b = bv; cin = cv; sub = sv & SUB_EN;
    in_valid = 1'b1;
    r = ref_op(a, b, cin, sub);
    exp_sum  = r[7:0];
    exp_cout = r[8];
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic run_op(input logic [7:0] av, input logic [7:0] bv,
                        input logic cv, input logic sv);
    int         lat [4];
    logic [7:0] gs  [4];
    logic       gc  [4];
    logic       rdy [4];
    for (int i = 0; i < 4; i++) begin
      lat[i] = 0; gs[i] = 'x; gc[i] = 1'bx; rdy[i] = 1'b0;
    end
    start_op(av, bv, cv, sv);
    for (int n = 1; n <= 12; n++) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        if (lat[i] != 0 && n == lat[i] + 1) rdy[i] = in_ready_v[i];
        if (out_valid_v[i] && lat[i] == 0) begin
          lat[i] = n; gs[i] = sum_v[i]; gc[i] = cout_v[i];
        end
      end
    end
    for (int i = 0; i < 4; i++) begin
      check("latency", 1 << i, lat[i], (8 >> i) + 1);
      check("sum", 1 << i, gs[i], exp_sum);
      check("cout", 1 << i, gc[i], exp_cout);
      check("in_ready after result", 1 << i, rdy[i], 1);
    end
  endtask

  initial begin
    logic seen;
    int   w;
    rst_n = 1'b0; in_valid = 1'b0; cin = 1'b0; out_ready = 1'b1; sub = 1'b0;
    a = '0; b = '0;
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("reset in_ready", 1 << i, in_ready_v[i], 1);
      check("reset out_valid", 1 << i, out_valid_v[i], 0);
      check("reset busy", 1 << i, busy_v[i], 0);
      check("reset sum", 1 << i, sum_v[i], 0);
      check("reset cout", 1 << i, cout_v[i], 0);
    end
    @(negedge clk) rst_n = 1'b1;

    run_op(8'h5A, 8'h3C, 1'b0, 1'b0);
    run_op(8'hFF, 8'h01, 1'b0, 1'b0);
    run_op(8'hFF, 8'hFF, 1'b1, 1'b0);

    // Backpressure: hold results while a stray in_valid is presented.
    @(negedge clk) out_ready = 1'b0;
    start_op(8'hA5, 8'h5B, 1'b1, 1'b0);
    w = 0;
    while (!out_valid_v[0] && w < 20) begin
      @(posedge clk);
      #1 w++;
    end
    check("bp result arrives", 1, out_valid_v[0], 1);
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      in_valid = 1'b1; a = 8'($urandom); b = 8'($urandom);
      @(posedge clk);
      #1;
      for (int i = 0; i < 4; i++) begin
        check("bp out_valid", 1 << i, out_valid_v[i], 1);
        check("bp sum", 1 << i, sum_v[i], exp_sum);
        check("bp cout", 1 << i, cout_v[i], exp_cout);
        check("bp in_ready", 1 << i, in_ready_v[i], 0);
      end
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      check("bp release out_valid", 1 << i, out_valid_v[i], 0);
      check("bp release in_ready", 1 << i, in_ready_v[i], 1);
    end

    // Reset sampled at accept edge + 2 abandons the operation.
    start_op(8'h77, 8'h11, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1 seen = seen | (|out_valid_v);
    end
    check("abandoned op emitted", 0, seen, 0);
    for (int i = 0; i < 4; i++) begin
      check("post-reset sum", 1 << i, sum_v[i], 0);
      check("post-reset cout", 1 << i, cout_v[i], 0);
      check("post-reset in_ready", 1 << i, in_ready_v[i], 1);
    end
    run_op(8'h01, 8'h02, 1'b0, 1'b0);

`ifdef SERIAL_DIGIT_ADDER_SUB_EN
    run_op(8'h10, 8'h20, 1'b0, 1'b1);
    check("sub 10-20 sum", 0, exp_sum, 8'hF0);
    run_op(8'h20, 8'h10, 1'b0, 1'b1);
    check("sub 20-10 cout", 0, exp_cout, 1);
`endif

    repeat (256) begin
      run_op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom) & SUB_EN);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
